uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-line receiver that turns an asynchronous 8N1 UART bit stream into bytes.
- Presents each byte on a valid/ready byte interface.
- Sits directly upstream of the host-interface bridge; its rx_valid/rx_data/rx_ready connect one-to-one to the bridge's host-side ports.
- Samples each bit at mid-bit, rejects start-bit glitches, reports framing errors and overruns.

Parameters:
- CLOCK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, line bit rate.
- DIVISOR (localparam), CLOCK_HZ/BAUD rounded down, clock cycles per bit. Elaboration fails if it is below 4.
- FIFO_DEPTH, 4, entries in the optional output FIFO. Must be a power of two, at least 2. Used only when UART_RX_FIFO_EN is defined.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- serial_in  in  1  UART line, idle high, asynchronous to clock.
- rx_ready  in  1  consumer can accept a byte this cycle.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_data  out  8  received byte, LSB first on the line.
- framing_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped because there was no room.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; both synchroniser flops = 1.
  - rx_valid = 0, rx_data = 0x00, framing_error = 0, overrun = 0.
  - Bit counter = 0, shift register = 0.
- Input path: serial_in passes a 2-flop synchroniser; "s" below denotes the synchronised value.
- Counter: cnt decrements every cycle outside IDLE and BREAK. "tick" = cnt==0 in that cycle.
- States:
  - IDLE: if s==0, cnt <= DIVISOR/2-1 and go to START.
  - START: on tick, if s==0: cnt <= DIVISOR-1, bitidx <= 0, go to DATA. If s==1 (glitch), go to IDLE with no outputs.
  - DATA: on tick, shreg <= {s, shreg[7:1]} and cnt <= DIVISOR-1. If bitidx==7 go to STOP, else bitidx++.
  - STOP: on tick, if s==1 the frame is good: deliver shreg (see holding rules) and go to IDLE. If s==0: framing_error = 1 for one cycle, byte discarded, go to BREAK.
  - BREAK: stay until s==1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- Latency: the first clock edge at which serial_in is low, to rx_valid high, is 2 + DIVISOR/2 + 9*DIVISOR cycles. This assumes the line is ideal and the holding register is empty.
- Output handshake:
  - A byte transfers on the cycle where rx_valid & rx_ready.
  - rx_data is stable while rx_valid=1.
  - rx_valid never drops without a transfer, except on reset.
- Holding register (no FIFO):
  - A good frame loads if rx_valid==0 or the current cycle transfers. In the transfer case, the new byte loads, rx_valid stays 1, and there is no overrun.
  - Otherwise: overrun = 1 for one cycle, the new byte is dropped, and the old byte is kept.
- framing_error and overrun are never asserted in the same cycle.
- Reset mid-frame: the partial byte is lost and the next start bit after release is decoded normally.

Optional Feature:
- Macro: UART_RX_FIFO_EN.
- Defined: good frames push into a FIFO_DEPTH-entry FIFO and rx_valid = FIFO not empty.
  - rx_data = head entry, shown combinationally from the FIFO read port.
  - Pop and push in the same cycle are allowed when full.
  - overrun pulses only if the FIFO is full and there is no pop that cycle.
  - Reset empties the FIFO.
- Undefined: a single holding register as described above, and FIFO_DEPTH is ignored.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE=0, START=1, DATA=2, STOP=3, BREAK=4 (3 bits);
  - the DIVISOR computation function;
  - minimum-divisor constant 4.
- Sub-module uart_rx_fifo (synchronous FIFO, push/pop/full/empty, reset_n async) is instantiated only under UART_RX_FIFO_EN.

Test Plan:
1. CLOCK_HZ=1_843_200, BAUD=115_200 (DIVISOR=16), rx_ready=1, send 0x55 -> rx_valid high exactly 154 cycles after the first low sample, rx_data=0x55 for one cycle, no error pulses.
2. serial_in low for 4 cycles, then high -> FSM returns to IDLE, no rx_valid, no framing_error; a following 0xC3 frame is received correctly.
3. Frame 0x81 with stop bit 0, line held low 40 cycles -> one framing_error pulse, no rx_valid, FSM stays in BREAK until the line goes high; the next 0x0F frame is received.
4. rx_ready=0, send 0xA5 then 0x3C -> rx_data=0xA5 held, one overrun pulse at the 0x3C stop tick. With UART_RX_FIFO_EN (depth 4), send 5 bytes -> overrun on the 5th only, then pops return the first 4 in order.
5. rx_ready=0, 0xA5 pending, raise rx_ready exactly on the 0x3C stop tick -> 0xA5 transfers, 0x3C presented the next cycle, no overrun.
6. Assert reset_n low mid-DATA of 0xFF for 3 cycles -> all outputs reset immediately, no rx_valid for the partial byte; the next 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and bit-period math.
package uart_pkg;

  localparam int MIN_DIVISOR = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  function automatic int calc_divisor(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; read data is the head entry, shown combinationally.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection and a valid/ready byte port.
// Define UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO instead of one holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       framing_error,
  output logic       overrun
);

  localparam int DIVISOR = calc_divisor(CLOCK_HZ, BAUD);
  localparam int CNT_W   = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);

  if (DIVISOR < MIN_DIVISOR) begin : g_bad_divisor
    $error("uart_rx: CLOCK_HZ/BAUD must be at least 4");
  end

  rx_state_t        state;
  rx_state_t        next_state;
  logic             sync_meta;
  logic             sync_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bitidx;
  logic [7:0]       shreg;
  logic             tick;
  logic             load_half;
  logic             load_full;
  logic             shift;
  logic             good_frame;
  logic             bad_frame;
  logic             transfer;
  logic             drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      sync_s    <= 1'b1;
    end else begin
      sync_meta <= serial_in;
      sync_s    <= sync_meta;
    end
  end

  assign tick     = (cnt == '0);
  assign transfer = rx_valid & rx_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!sync_s) next_state = START;
      START:   if (tick) next_state = sync_s ? IDLE : DATA;
      DATA:    if (tick && bitidx == 3'd7) next_state = STOP;
      STOP:    if (tick) next_state = sync_s ? IDLE : BREAK;
      BREAK:   if (sync_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_half  = 1'b0;
    load_full  = 1'b0;
    shift      = 1'b0;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    case (state)
      IDLE:  load_half = ~sync_s;
      START: load_full = tick & ~sync_s;
      DATA: begin
        shift     = tick;
        load_full = tick;
      end
      STOP: begin
        good_frame = tick & sync_s;
        bad_frame  = tick & ~sync_s;
      end
      default: ;
    endcase
  end

  // The bit counter free-runs only while a frame is in flight; IDLE and BREAK park it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
    end else begin
      if (load_half)                          cnt <= CNT_HALF;
      else if (load_full)                     cnt <= CNT_FULL;
      else if (state != IDLE && state != BREAK) cnt <= cnt - 1'b1;
      if (state == START) bitidx <= '0;
      else if (shift)     bitidx <= bitidx + 3'd1;
      if (shift) shreg <= {sync_s, shreg[7:1]};
    end
  end

`ifdef UART_RX_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (good_frame),
    .pop     (transfer),
    .wr_data (shreg),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;
  assign rx_data  = fifo_empty ? 8'h00 : fifo_head;
  assign drop     = good_frame & fifo_full & ~transfer;
`else
  // A new byte may replace the held one only in the cycle the held one is consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else if (good_frame && (!rx_valid || transfer)) begin
      rx_valid <= 1'b1;
      rx_data  <= shreg;
    end else if (transfer) begin
      rx_valid <= 1'b0;
    end
  end

  assign drop = good_frame & rx_valid & ~transfer;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= bad_frame;
      overrun       <= drop;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized checks of uart_rx at 16 clocks per bit against a byte-level line model.
module tb_uart_rx;

  localparam int D   = 16;
  localparam int LAT = 2 + D / 2 + 9 * D;

  logic       clock;
  logic       reset_n;
  logic       serial_in;
  logic       rx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       framing_error;
  logic       overrun;

  uart_rx #(.CLOCK_HZ(1_843_200), .BAUD(115_200)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .serial_in     (serial_in),
    .rx_ready      (rx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         chk_n = 0;
  int         err_n = 0;
  int         cyc = 0;
  int         rise_cyc = -1;
  int         fe_n = 0;
  int         fe_cyc = -1;
  int         ov_n = 0;
  int         ov_cyc = -1;
  int         both_n = 0;
  int         valid_hi_n = 0;
  int         hold_viol = 0;
  logic       prev_valid = 1'b0;
  logic       prev_xfer = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] sent_q[$];

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    chk_n++;
    assert (observed === expected) else begin
      err_n++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD;
  endfunction

  task automatic clear_obs();
    got_q.delete();
    rise_cyc = -1;
    fe_n = 0;
    fe_cyc = -1;
    ov_n = 0;
    ov_cyc = -1;
    valid_hi_n = 0;
  endtask

  // One clock: apply inputs, log a transfer, then observe what the edge produced.
  task automatic step(input logic ser, input logic rdy);
    serial_in = ser;
    rx_ready  = rdy;
    if (reset_n && rx_valid && rdy) got_q.push_back(rx_data);
    prev_valid = rx_valid;
    prev_data  = rx_data;
    prev_xfer  = rx_valid & rdy;
    @(posedge clock);
    #1;
    cyc++;
    if (reset_n) begin
      if (prev_valid && !prev_xfer && (!rx_valid || rx_data !== prev_data)) hold_viol++;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      if (rx_valid) valid_hi_n++;
      if (framing_error) begin fe_n++; fe_cyc = cyc; end
      if (overrun) begin ov_n++; ov_cyc = cyc; end
      if (framing_error && overrun) both_n++;
    end
  endtask

  function automatic logic pick_ready(input int mode);
    return (mode == 2) ? logic'($urandom_range(0, 1)) : logic'(mode == 1);
  endfunction

  task automatic idle(input int n, input int mode);
    repeat (n) step(1'b1, pick_ready(mode));
  endtask

  // start = the cycle number of the first edge that samples the start bit.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit, input int mode,
                                input int pulse_at, output int start);
    logic bitv;
    logic rdy;
    start = cyc + 1;
    for (int b = 0; b < 10; b++) begin
      bitv = (b == 0) ? 1'b0 : (b == 9) ? stop_bit : data[b-1];
      for (int k = 0; k < D; k++) begin
        rdy = pick_ready(mode);
        if (b * D + k == pulse_at) rdy = 1'b1;
        step(bitv, rdy);
      end
    end
  endtask

  initial begin
    int s0;
    int s1;
    logic [7:0] b;
    logic [7:0] fifo_bytes [5];

    serial_in = 1'b1;
    rx_ready  = 1'b0;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_output("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check_output("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check_output("reset_framing_error", {31'h0, framing_error}, 32'h0);
    check_output("reset_overrun", {31'h0, overrun}, 32'h0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    idle(10, 1);

    $display("[TB] basic frame and latency");
    clear_obs();
    apply_stimulus(8'h55, 1'b1, 1, -1, s0);
    idle(5, 1);
    check_output("t1_latency", rise_cyc, s0 + LAT);
    check_output("t1_count", got_q.size(), 1);
    check_output("t1_data", got_at(0), 32'h55);
    check_output("t1_valid_cycles", valid_hi_n, 1);
    check_output("t1_fe", fe_n, 0);
    check_output("t1_ov", ov_n, 0);

    $display("[TB] start-bit glitch");
    clear_obs();
    repeat (4) step(1'b0, 1'b1);
    idle(30, 1);
    check_output("t2_glitch_valid", valid_hi_n, 0);
    check_output("t2_glitch_fe", fe_n, 0);
    apply_stimulus(8'hC3, 1'b1, 1, -1, s0);
    idle(5, 1);
    check_output("t2_count", got_q.size(), 1);
    check_output("t2_data", got_at(0), 32'hC3);

    $display("[TB] framing error and break");
    clear_obs();
    apply_stimulus(8'h81, 1'b0, 1, -1, s0);
    repeat (40) step(1'b0, 1'b1);
    idle(30, 1);
    check_output("t3_fe_count", fe_n, 1);
    check_output("t3_fe_cycle", fe_cyc, s0 + LAT);
    check_output("t3_no_valid", valid_hi_n, 0);
    apply_stimulus(8'h0F, 1'b1, 1, -1, s0);
    idle(5, 1);
    check_output("t3_next_count", got_q.size(), 1);
    check_output("t3_next_data", got_at(0), 32'h0F);
    check_output("t3_fe_after", fe_n, 1);

`ifdef UART_RX_FIFO_EN
    $display("[TB] fifo overrun");
    clear_obs();
    fifo_bytes = '{8'hA5, 8'h3C, 8'h11, 8'h22, 8'h33};
    s1 = 0;
    for (int i = 0; i < 5; i++) apply_stimulus(fifo_bytes[i], 1'b1, 0, -1, s1);
    idle(5, 0);
    check_output("t4_ov_count", ov_n, 1);
    check_output("t4_ov_cycle", ov_cyc, s1 + LAT);
    check_output("t4_head", {24'h0, rx_data}, 32'hA5);
    idle(10, 1);
    check_output("t4_drain_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check_output($sformatf("t4_drain_%0d", i), got_at(i), {24'h0, fifo_bytes[i]});
    check_output("t4_empty", {31'h0, rx_valid}, 32'h0);
`else
    $display("[TB] holding register overrun");
    clear_obs();
    apply_stimulus(8'hA5, 1'b1, 0, -1, s0);
    apply_stimulus(8'h3C, 1'b1, 0, -1, s1);
    idle(5, 0);
    check_output("t4_valid_held", {31'h0, rx_valid}, 32'h1);
    check_output("t4_data_held", {24'h0, rx_data}, 32'hA5);
    check_output("t4_ov_count", ov_n, 1);
    check_output("t4_ov_cycle", ov_cyc, s1 + LAT);
    check_output("t4_no_xfer", got_q.size(), 0);
    idle(3, 1);
    check_output("t4_drain_count", got_q.size(), 1);
    check_output("t4_drain_data", got_at(0), 32'hA5);
    check_output("t4_empty", {31'h0, rx_valid}, 32'h0);
`endif

    $display("[TB] transfer on stop tick");
    clear_obs();
    apply_stimulus(8'hA5, 1'b1, 0, -1, s0);
    apply_stimulus(8'h3C, 1'b1, 0, LAT, s1);
    check_output("t5_count", got_q.size(), 1);
    check_output("t5_first", got_at(0), 32'hA5);
    check_output("t5_valid", {31'h0, rx_valid}, 32'h1);
    check_output("t5_next", {24'h0, rx_data}, 32'h3C);
    check_output("t5_ov", ov_n, 0);

    $display("[TB] reset mid-frame");
    repeat (D) step(1'b0, 1'b0);
    repeat (3 * D) step(1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_valid", {31'h0, rx_valid}, 32'h0);
    check_output("t6_rst_data", {24'h0, rx_data}, 32'h0);
    check_output("t6_rst_fe_ov", {30'h0, framing_error, overrun}, 32'h0);
    repeat (3) step(1'b1, 1'b0);
    reset_n = 1'b1;
    clear_obs();
    repeat (6 * D) step(1'b1, 1'b1);
    check_output("t6_no_partial", valid_hi_n, 0);
    apply_stimulus(8'h7E, 1'b1, 1, -1, s0);
    idle(5, 1);
    check_output("t6_count", got_q.size(), 1);
    check_output("t6_data", got_at(0), 32'h7E);

    $display("[TB] random bytes with random ready");
    clear_obs();
    sent_q.delete();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      sent_q.push_back(b);
      apply_stimulus(b, 1'b1, 2, -1, s0);
      idle($urandom_range(0, 15), 2);
    end
    idle(20, 1);
    check_output("rnd_count", got_q.size(), sent_q.size());
    for (int i = 0; i < sent_q.size(); i++) check_output($sformatf("rnd_byte_%0d", i), got_at(i), {24'h0, sent_q[i]});
    check_output("rnd_ov", ov_n, 0);
    check_output("rnd_fe", fe_n, 0);

    check_output("hold_stability", hold_viol, 0);
    check_output("fe_ov_exclusive", both_n, 0);

    $display("Result: errors=%0d of %0d checks", err_n, chk_n);
    $finish;
  end

endmodule
